// File: rtl/prog_loader_if.sv
// Program-load stream between the harness and prog_loader.
// The source drives valid/data/last; the loader answers with ready.
interface prog_loader_if #(
    parameter int W = 9
) ();
    logic         ld_valid;
    logic [W-1:0] ld_data;
    logic         ld_last;
    logic         ld_ready;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready
    );
endinterface

// File: rtl/prog_loader.sv
// Harness stage for the 9-bit core: streams a program into instruction memory,
// holds the core in reset while loading, starts it, and times the run until done.
//
// state | meaning
// IDLE  | waiting for the first word of a program
// LOAD  | accepting words and writing them to imem
// ARM   | final imem write in flight, core still in reset
// START | core released, one-cycle req pulse
// RUN   | counting cycles until core_done
// DONE  | results held; a new word starts the next load
module prog_loader #(
    parameter int D  = 12,
    parameter int W  = 9,
    parameter int CW = 16
) (
    input  logic                clk,
    input  logic                reset,
    prog_loader_if.slave        ld,
    output logic                imem_we,
    output logic [D-1:0]        imem_addr,
    output logic [W-1:0]        imem_wdata,
    output logic                core_reset,
    output logic                core_req,
    input  logic                core_done,
    output logic                busy,
    output logic                run_done,
    output logic                err_overflow,
    output logic [D:0]          prog_len,
    output logic [CW-1:0]       cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [D:0]    WP_ONE = (D+1)'(1);
    localparam logic [CW-1:0] CC_ONE = CW'(1);
    localparam logic [CW-1:0] CC_MAX = {CW{1'b1}};

    state_t          r_state;
    logic            r_ld_ready;
    logic            r_imem_we;
    logic [D-1:0]    r_imem_addr;
    logic [W-1:0]    r_imem_wdata;
    logic            r_core_reset;
    logic            r_core_req;
    logic            r_busy;
    logic            r_run_done;
    logic            r_err_overflow;
    logic [D:0]      r_wp;
    logic [CW-1:0]   r_cycle_count;

    logic            w_accept;
    logic            w_full;

    assign w_accept = ld.ld_valid && r_ld_ready;
    // wp never exceeds 2^D, so its top bit alone flags a full memory
    assign w_full   = r_wp[D];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_ld_ready     <= 1'b1;
            r_imem_we      <= 1'b0;
            r_imem_addr    <= '0;
            r_imem_wdata   <= '0;
            r_core_reset   <= 1'b1;
            r_core_req     <= 1'b0;
            r_busy         <= 1'b0;
            r_run_done     <= 1'b0;
            r_err_overflow <= 1'b0;
            r_wp           <= '0;
            r_cycle_count  <= '0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_run_done     <= 1'b0;
                        r_err_overflow <= 1'b0;
                        r_cycle_count  <= '0;
                        r_core_reset   <= 1'b1;
                        r_busy         <= 1'b1;
                        r_imem_we      <= 1'b1;
                        r_imem_addr    <= '0;
                        r_imem_wdata   <= ld.ld_data;
                        r_wp           <= WP_ONE;
                        if (ld.ld_last) begin
                            r_state    <= S_ARM;
                            r_ld_ready <= 1'b0;
                        end else begin
                            r_state    <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_full) begin
                            // overflow word is dropped; the core is never started
                            r_err_overflow <= 1'b1;
                            r_run_done     <= 1'b0;
                            r_busy         <= 1'b0;
                            r_state        <= S_DONE;
                        end else begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_wp[D-1:0];
                            r_imem_wdata <= ld.ld_data;
                            r_wp         <= r_wp + WP_ONE;
                            if (ld.ld_last) begin
                                r_state    <= S_ARM;
                                r_ld_ready <= 1'b0;
                            end
                        end
                    end
                end
                S_ARM: begin
                    r_state      <= S_START;
                    r_core_reset <= 1'b0;
                    r_core_req   <= 1'b1;
                end
                S_START: begin
                    r_state    <= S_RUN;
                    r_core_req <= 1'b0;
                end
                S_RUN: begin
                    if (r_cycle_count != CC_MAX) begin
                        r_cycle_count <= r_cycle_count + CC_ONE;
                    end
                    if (core_done) begin
                        r_state    <= S_DONE;
                        r_run_done <= 1'b1;
                        r_busy     <= 1'b0;
                        r_ld_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ld.ld_ready   = r_ld_ready;
    assign imem_we       = r_imem_we;
    assign imem_addr     = r_imem_addr;
    assign imem_wdata    = r_imem_wdata;
    assign core_reset    = r_core_reset;
    assign core_req      = r_core_req;
    assign busy          = r_busy;
    assign run_done      = r_run_done;
    assign err_overflow  = r_err_overflow;
    assign prog_len      = r_wp;
    assign cycle_count   = r_cycle_count;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream harness stage for the 9-bit single-cycle core.
- Accepts a machine-code program over a valid/ready stream and writes it into instruction memory from address 0.
- Holds the core in reset while the program is loaded, then releases it and pulses its `req` input.
- Waits for the core's `done` and reports the run length in cycles plus status flags.

Parameters:
- D, 12: instruction-memory address width; equals the core's program-counter width.
- W, 9: machine-code word width.
- CW, 16: width of the cycle counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ld_valid  in  1  a program word is offered.
- ld_data  in  W  the program word.
- ld_last  in  1  marks the final word of the program; qualified by ld_valid.
- ld_ready  out  1  loader can accept a word this cycle.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  D  instruction-memory write address.
- imem_wdata  out  W  instruction-memory write data.
- core_reset  out  1  drives the core's reset.
- core_req  out  1  drives the core's req; one-cycle start pulse.
- core_done  in  1  the core's done output.
- busy  out  1  high in LOAD, ARM, START and RUN.
- run_done  out  1  sticky: the last run completed normally.
- err_overflow  out  1  sticky: the program exceeded 2^D words.
- prog_len  out  D+1  number of words accepted in the current load.
- cycle_count  out  CW  number of RUN cycles in the last run.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high. Every output is registered.
- Reset values:
  - state = IDLE, core_reset = 1, ld_ready = 1.
  - All other outputs = 0, and the write pointer wp = 0.
- Reset asserted in any state, including mid-load or mid-run, forces these values on the next edge. A partially loaded program is abandoned.
- Accept: valid && ready at a rising edge.
- ld_ready is 1 in IDLE, LOAD and DONE; 0 in ARM, START and RUN.
- Write timing: an accepted word is written on the cycle after the accept edge.
  - imem_we = 1 for exactly that one cycle.
  - imem_addr = wp[D-1:0]; imem_wdata = the accepted word.
  - After the accept, wp and prog_len both increment.
  - No write occurs without an accept. Gaps in ld_valid produce no holes in the address sequence.
- IDLE or DONE, on an accepted word:
  - Clear run_done, err_overflow and cycle_count.
  - Set prog_len = 1, set core_reset = 1, and write the word at address 0.
  - Next state is ARM if ld_last, else LOAD.
- LOAD:
  - On an accepted word with wp < 2^D: write it; go to ARM if ld_last, else stay in LOAD.
  - On an accepted word with wp == 2^D (overflow):
    - The word is not written and prog_len is not incremented.
    - err_overflow = 1; next state is DONE with run_done = 0.
    - The core stays in reset (core_reset = 1) and core_req never pulses.
- ARM: lasts 1 cycle, which coincides with the final imem write. core_reset stays 1. Next state is START.
- START: lasts 1 cycle, with core_reset = 0 and core_req = 1. Next state is RUN.
- RUN:
  - core_req = 0.
  - cycle_count increments every RUN cycle, saturating at 2^CW-1.
  - When core_done is sampled high, that cycle is counted; next state is DONE.
  - core_done is ignored outside RUN.
- DONE:
  - run_done = 1 unless entered through overflow.
  - core_reset = 0 after a normal run, so core state stays inspectable.
  - cycle_count and prog_len hold their values.
- Single-word program (ld_last on the first word): prog_len = 1, and the sequence runs IDLE→ARM→START→RUN.
- Timing from the accept edge k of the last word:
  - core_req is high during cycle k+2.
  - The first RUN cycle is k+3.

Test Plan:
- Load 0x0A3, 0x1FF, 0x000 (ld_last on the 3rd) → imem writes addr 0, 1, 2 with matching data, one cycle after each accept; prog_len = 3; core_reset falls and core_req pulses once, exactly 2 cycles after the last accept.
- Same program with ld_valid low for 2 cycles between words → writes are still at addr 0, 1, 2 with no duplicates; ld_ready stays 0 from ARM until DONE.
- core_done raised on the 10th RUN cycle → cycle_count = 10, run_done = 1, busy = 0, core_reset stays 0. With CW = 4 and done on the 20th cycle → cycle_count = 15.
- D = 3, 9 words with no ld_last → writes to addr 0–7 only; the 9th word is dropped; err_overflow = 1, run_done = 0, prog_len = 8; no core_req pulse.
- Reset asserted mid-LOAD and again mid-RUN → the next cycle shows state IDLE, core_reset = 1, ld_ready = 1, all counters and flags 0; a subsequent load starts at addr 0.
- From DONE, offer a new 1-word program → run_done and cycle_count clear on the accept edge, core_reset = 1, the word is written at addr 0, and a new core_req pulse follows 2 cycles after the accept.
